// File: rtl/predictor_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// predictor_update_ctrl_pkg : sizes, FSM encoding and feedback entry layout
// Rev 1.0
// ============================================================================
package predictor_update_ctrl_pkg;

    localparam int MEM_SIZE   = 1024;
    localparam int IDX_W      = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef struct packed {
        logic [IDX_W-1:0] indx;
        logic             taken;
    } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/predictor_update_ctrl_fb_fifo.sv
`default_nettype none
// ============================================================================
// pred_fb_fifo : synchronous feedback FIFO with flush, count-based full/empty
// Rev 1.0
// ============================================================================
module pred_fb_fifo
    import predictor_update_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int PW    = PTR_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  fb_entry_t push_data,
    input  logic      pop,
    output fb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    fb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == C_FULL);
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/predictor_update_ctrl.sv
`default_nettype none
// ============================================================================
// predictor_update_ctrl : sequences the predictor write port (clear + feedback)
// Rev 1.0
// ============================================================================
module predictor_update_ctrl
    import predictor_update_ctrl_pkg::*;
(
    input  logic             puc_clock_in,
    input  logic             puc_reset_in,
    input  logic             puc_clear_req_in,
    input  logic             puc_hold_in,
    input  logic             puc_res_valid_in,
    output logic             puc_res_ready_out,
    input  logic [IDX_W-1:0] puc_res_indx_in,
    input  logic             puc_res_taken_in,
    input  logic             puc_res_mispred_in,
    input  logic [31:0]      puc_res_target_in,
    output logic             puc_pred_write_enable_out,
    output logic             puc_pred_taken_out,
    output logic [IDX_W-1:0] puc_pred_indx_out,
    output logic             puc_redirect_valid_out,
    output logic [31:0]      puc_redirect_pc_out,
    output logic             puc_busy_out,
    output logic [31:0]      puc_mispred_count_out
);

    // Two passes over the table: the predictor shifts {old[0], taken}.
    localparam logic [IDX_W:0] C_CLR_LAST = (IDX_W+1)'(2*MEM_SIZE-1);

    logic [0:0]     r_state;
    logic [IDX_W:0] r_clr_cnt;
    logic           r_redirect_valid;
    logic [31:0]    r_redirect_pc;
    logic [31:0]    r_mispred_count;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_mispred_acc;
    fb_entry_t      w_head;
    fb_entry_t      w_push_data;

    assign puc_res_ready_out = !w_full && !puc_clear_req_in;
    assign w_push            = puc_res_valid_in && puc_res_ready_out;
    assign w_pop             = (r_state == ST_RUN) && !w_empty && !puc_hold_in;
    assign w_mispred_acc     = w_push && puc_res_mispred_in;
    assign w_push_data       = '{indx: puc_res_indx_in, taken: puc_res_taken_in};

    pred_fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PW    (PTR_W)
    ) u_fb_fifo (
        .clk       (puc_clock_in),
        .rst       (puc_reset_in),
        .flush     (puc_clear_req_in),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        puc_pred_write_enable_out = 1'b0;
        puc_pred_indx_out         = '0;
        puc_pred_taken_out        = 1'b0;
        if (r_state == ST_CLEAR) begin
            puc_pred_write_enable_out = 1'b1;
            puc_pred_indx_out         = r_clr_cnt[IDX_W-1:0];
        end else if (w_pop) begin
            puc_pred_write_enable_out = 1'b1;
            puc_pred_indx_out         = w_head.indx;
            puc_pred_taken_out        = w_head.taken;
        end
    end

    always_ff @(posedge puc_clock_in) begin
        if (puc_reset_in || puc_clear_req_in) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_cnt == C_CLR_LAST) begin
                r_state   <= ST_RUN;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge puc_clock_in) begin
        if (puc_reset_in) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispred_count  <= '0;
        end else begin
            r_redirect_valid <= w_mispred_acc;
            if (w_mispred_acc) begin
                r_redirect_pc <= puc_res_target_in;
                if (r_mispred_count != '1) begin
                    r_mispred_count <= r_mispred_count + 32'd1;
                end
            end
        end
    end

    assign puc_redirect_valid_out = r_redirect_valid;
    assign puc_redirect_pc_out    = r_redirect_pc;
    assign puc_mispred_count_out  = r_mispred_count;
    assign puc_busy_out           = (r_state == ST_CLEAR);

endmodule
`default_nettype wire
